// File: rtl/keypad_entry.sv
// -----------------------------------------------------------------------------
// keypad_entry
//   Operand input path for the calculator. Scans a 4x4 active-low matrix
//   keypad one column at a time, debounces complete scan frames and assembles
//   accepted digit keys into a 32-bit two's-complement operand, in decimal or
//   hex depending on the display radix.
//
// Parameters
//   SCAN_DIV    clock cycles each column is driven (>= 4)
//   DEBOUNCE    identical frames needed to accept a press or a release (>= 2)
//   MAX_DIGITS  maximum number of significant digits in an entry
//
// Ports
//   clock        in   system clock
//   reset_n      in   asynchronous active-low reset
//   show_in_hex  in   entry radix, 1 = hex, 0 = decimal
//   clear        in   synchronous clear of the current entry
//   rows[3:0]    in   keypad rows, active-low, asynchronous
//   cols[3:0]    out  keypad column drive, active-low one-hot
//   value[31:0]  out  entered operand, two's complement
//   digit_count  out  significant digits entered
//   key_valid    out  one-cycle pulse per accepted key press
//   key_code     out  code (row*4+col) of the last accepted key
//   overflow     out  one-cycle pulse when a digit is rejected (entry full)
//
// Configuration
//   KEYPAD_SIGN_KEY_EN : in decimal mode code 15 toggles the sign and code 14
//                        is backspace. Undefined: both codes are ignored.
// -----------------------------------------------------------------------------
module keypad_entry #(
    parameter int SCAN_DIV   = 8192,
    parameter int DEBOUNCE   = 4,
    parameter int MAX_DIGITS = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        show_in_hex,
    input  logic        clear,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    output logic [31:0] value,
    output logic [3:0]  digit_count,
    output logic        key_valid,
    output logic [4:0]  key_code,
    output logic        overflow
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);
    localparam logic [SW-1:0] STABLE_ONE = SW'(1);
    localparam logic [3:0]    DIGITS_MAX = 4'(MAX_DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEB  = 2'd1,
        ST_HELD = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    // Synchroniser and scan registers
    logic [3:0]    rows_meta_q;
    logic [3:0]    rows_sync_q;
    logic [CW-1:0] scan_cnt_q;
    logic [1:0]    col_q;
    logic [3:0]    cols_q;
    logic [15:0]   frame_q;

    // Debounce FSM
    state_t        state_q, state_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [3:0]    key_q, key_d;

    // Entry registers
    logic [31:0]   mag_q, mag_d;
    logic          sign_q, sign_d;
    logic [3:0]    count_q, count_d;
    logic          hex_prev_q;
    logic [31:0]   value_q;
    logic          key_valid_q;
    logic [4:0]    key_code_q;
    logic          overflow_q;

    // Combinational helpers
    logic          scan_tick_s;
    logic          frame_done_s;
    logic [15:0]   frame_full_s;
    logic [4:0]    ones_s;
    logic          cand_valid_s;
    logic [3:0]    cand_code_s;
    logic [SW-1:0] stable_inc_s;
    logic          accept_s;
    logic          hex_chg_s;
    logic          is_digit_s;
    logic          ovf_s;
`ifdef KEYPAD_SIGN_KEY_EN
    logic [31:0]   mag_div10_s;
`endif

    assign scan_tick_s  = (scan_cnt_q == SCAN_LAST);
    assign frame_done_s = scan_tick_s && (col_q == 2'd3);
    assign stable_inc_s = stable_q + STABLE_ONE;
    assign hex_chg_s    = show_in_hex ^ hex_prev_q;
    assign is_digit_s   = show_in_hex | (key_q <= 4'd9);
`ifdef KEYPAD_SIGN_KEY_EN
    assign mag_div10_s  = mag_q / 32'd10;
`endif

    assign cols        = cols_q;
    assign value       = value_q;
    assign digit_count = count_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign overflow    = overflow_q;

    // Two-flop synchroniser for the asynchronous row inputs (idle = all high)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rows_meta_q <= 4'hF;
            rows_sync_q <= 4'hF;
        end else begin
            rows_meta_q <= rows;
            rows_sync_q <= rows_meta_q;
        end
    end

    // Current frame with the active column's samples merged in; bit index is {row, col}
    always_comb begin
        frame_full_s = frame_q;
        for (int r = 0; r < 4; r++) begin
            frame_full_s[{2'(r), col_q}] = ~rows_sync_q[r];
        end
    end

    // Column scan counter, column drive and frame capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt_q <= {CW{1'b0}};
            col_q      <= 2'd0;
            cols_q     <= 4'b1110;
            frame_q    <= 16'h0000;
        end else if (scan_tick_s) begin
            scan_cnt_q <= {CW{1'b0}};
            col_q      <= col_q + 2'd1;
            cols_q     <= ~(4'b0001 << (col_q + 2'd1));
            frame_q    <= frame_full_s;
        end else begin
            scan_cnt_q <= scan_cnt_q + CW'(1);
        end
    end

    // Frame decode: a candidate exists only when exactly one key is down
    always_comb begin
        ones_s       = 5'd0;
        cand_code_s  = 4'd0;
        cand_valid_s = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (frame_full_s[i]) begin
                ones_s      = ones_s + 5'd1;
                cand_code_s = 4'(i);
            end else begin
                ones_s      = ones_s;
            end
        end
        cand_valid_s = (ones_s == 5'd1);
    end

    // Debounce FSM next state, evaluated only on the frame-complete cycle
    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        key_d    = key_q;
        accept_s = 1'b0;
        if (frame_done_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (cand_valid_s) begin
                        key_d    = cand_code_s;
                        stable_d = STABLE_ONE;
                        state_d  = ST_DEB;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_DEB: begin
                    if (cand_valid_s && (cand_code_s == key_q)) begin
                        stable_d = stable_inc_s;
                        if (stable_inc_s == STABLE_MAX) begin
                            accept_s = 1'b1;
                            state_d  = ST_HELD;
                        end else begin
                            state_d  = ST_DEB;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    // No auto-repeat: only a clean "none" frame starts the release
                    if (!cand_valid_s) begin
                        stable_d = STABLE_ONE;
                        state_d  = ST_REL;
                    end else begin
                        state_d  = ST_HELD;
                    end
                end
                ST_REL: begin
                    if (!cand_valid_s) begin
                        stable_d = stable_inc_s;
                        if (stable_inc_s == STABLE_MAX) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_REL;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    stable_d = {SW{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Debounce FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            stable_q <= {SW{1'b0}};
            key_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            key_q    <= key_d;
        end
    end

    // Entry update: clear and radix change take priority over an accepted key
    always_comb begin
        mag_d   = mag_q;
        sign_d  = sign_q;
        count_d = count_q;
        ovf_s   = 1'b0;
        if (clear || hex_chg_s) begin
            mag_d   = 32'd0;
            sign_d  = 1'b0;
            count_d = 4'd0;
        end else if (accept_s) begin
            if (is_digit_s) begin
                if ((mag_q == 32'd0) && (key_q == 4'd0)) begin
                    // Leading zero is not significant
                    mag_d = mag_q;
                end else if (count_q >= DIGITS_MAX) begin
                    ovf_s = 1'b1;
                end else begin
                    if (show_in_hex) begin
                        mag_d = {mag_q[27:0], key_q};
                    end else begin
                        // mag*10 + d as (mag<<3) + (mag<<1) + d
                        mag_d = {mag_q[28:0], 3'b000} + {mag_q[30:0], 1'b0}
                              + {28'd0, key_q};
                    end
                    count_d = count_q + 4'd1;
                end
`ifdef KEYPAD_SIGN_KEY_EN
            end else if (key_q == 4'd15) begin
                if (mag_q != 32'd0) begin
                    sign_d = ~sign_q;
                end else begin
                    sign_d = sign_q;
                end
            end else if (key_q == 4'd14) begin
                if (count_q != 4'd0) begin
                    mag_d   = mag_div10_s;
                    count_d = count_q - 4'd1;
                    if (mag_div10_s == 32'd0) begin
                        sign_d = 1'b0;
                    end else begin
                        sign_d = sign_q;
                    end
                end else begin
                    mag_d = mag_q;
                end
`endif
            end else begin
                // Non-digit key in decimal mode: reported but no entry change
                mag_d = mag_q;
            end
        end else begin
            mag_d = mag_q;
        end
    end

    // Entry registers and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mag_q       <= 32'd0;
            sign_q      <= 1'b0;
            count_q     <= 4'd0;
            hex_prev_q  <= 1'b0;
            value_q     <= 32'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 5'd0;
            overflow_q  <= 1'b0;
        end else begin
            mag_q       <= mag_d;
            sign_q      <= sign_d;
            count_q     <= count_d;
            hex_prev_q  <= show_in_hex;
            value_q     <= sign_d ? (~mag_d + 32'd1) : mag_d;
            key_valid_q <= accept_s;
            key_code_q  <= accept_s ? {1'b0, key_q} : key_code_q;
            overflow_q  <= ovf_s;
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
module tb_keypad_entry;

    localparam int FRAME = 32;  // 4 columns x SCAN_DIV(8)

    logic        clock = 1'b0;
    logic        reset_n;
    logic        show_in_hex;
    logic        clear;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [31:0] value;
    logic [3:0]  digit_count;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        overflow;

    logic [15:0] keys;
    int n_total = 0;
    int n_bad   = 0;
    int kv_cnt  = 0;
    int ov_cnt  = 0;
    int ovkv_cnt = 0;
    int k0, o0, b0;

    always #5 clock = ~clock;

    keypad_entry #(.SCAN_DIV(8), .DEBOUNCE(4), .MAX_DIGITS(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .show_in_hex (show_in_hex),
        .clear       (clear),
        .rows        (rows),
        .cols        (cols),
        .value       (value),
        .digit_count (digit_count),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .overflow    (overflow)
    );

    // Keypad matrix model: a pressed key pulls its row low while its column is driven
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!cols[c] && keys[4*r+c]) rows[r] = 1'b0;
            end
        end
    end

    // Pulse counters sampled on the falling edge
    always @(negedge clock) begin
        if (key_valid) kv_cnt++;
        if (overflow) ov_cnt++;
        if (overflow && key_valid) ovkv_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic press_key(input int code);
        keys = 16'h0001 << code;
        repeat (8*FRAME) @(negedge clock);
        keys = 16'h0000;
        repeat (8*FRAME) @(negedge clock);
    endtask

    task automatic clear_entry();
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    // Returns at the first falling edge after the scan wraps back to column 0
    task automatic align_frame();
        int budget;
        budget = 200;
        while (cols !== 4'b0111 && budget > 0) begin @(negedge clock); budget--; end
        while (cols !== 4'b1110 && budget > 0) begin @(negedge clock); budget--; end
        check_val("align_budget", 32'(budget > 0), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        show_in_hex = 1'b0;
        clear = 1'b0;
        keys = 16'h0000;
        repeat (3) @(negedge clock);
        check_val("rst_cols", 32'(cols), 32'h0000000E);
        check_val("rst_value", value, 32'd0);
        check_val("rst_count", 32'(digit_count), 32'd0);
        check_val("rst_kv", 32'(key_valid), 32'd0);
        check_val("rst_code", 32'(key_code), 32'd0);
        check_val("rst_ovf", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Long hold of key 5 fires exactly once
        k0 = kv_cnt;
        keys = 16'h0020;
        repeat (20*FRAME) @(negedge clock);
        keys = 16'h0000;
        repeat (8*FRAME) @(negedge clock);
        check_val("hold_kv_once", 32'(kv_cnt - k0), 32'd1);
        check_val("hold_code", 32'(key_code), 32'd5);
        check_val("hold_value", value, 32'd5);
        check_val("hold_count", 32'(digit_count), 32'd1);

        clear_entry();
        check_val("clr_value", value, 32'd0);
        check_val("clr_count", 32'(digit_count), 32'd0);

        // Decimal entry
        press_key(1); press_key(2); press_key(3);
        check_val("dec_123", value, 32'd123);
        check_val("dec_123_cnt", 32'(digit_count), 32'd3);
        press_key(0);
        check_val("dec_1230", value, 32'd1230);
        check_val("dec_1230_cnt", 32'(digit_count), 32'd4);

        // Leading zero ignored
        clear_entry();
        k0 = kv_cnt;
        press_key(0);
        check_val("lz_kv", 32'(kv_cnt - k0), 32'd1);
        check_val("lz_value", value, 32'd0);
        check_val("lz_count", 32'(digit_count), 32'd0);

        // Hex entry then radix switch
        show_in_hex = 1'b1;
        repeat (2) @(negedge clock);
        press_key(10); press_key(15); press_key(3);
        check_val("hex_af3", value, 32'h00000AF3);
        check_val("hex_cnt", 32'(digit_count), 32'd3);
        show_in_hex = 1'b0;
        repeat (2) @(negedge clock);
        check_val("radix_clr_val", value, 32'd0);
        check_val("radix_clr_cnt", 32'(digit_count), 32'd0);
        k0 = kv_cnt;
        press_key(10);
        check_val("decA_kv", 32'(kv_cnt - k0), 32'd1);
        check_val("decA_code", 32'(key_code), 32'd10);
        check_val("decA_value", value, 32'd0);

        // Nine 9s: eight accepted, ninth overflows
        k0 = kv_cnt; o0 = ov_cnt; b0 = ovkv_cnt;
        for (int i = 0; i < 9; i++) press_key(9);
        check_val("ovf_value", value, 32'd99999999);
        check_val("ovf_count", 32'(digit_count), 32'd8);
        check_val("ovf_pulses", 32'(ov_cnt - o0), 32'd1);
        check_val("ovf_with_kv", 32'(ovkv_cnt - b0), 32'd1);
        check_val("ovf_kv", 32'(kv_cnt - k0), 32'd9);

        // Key toggled every frame never debounces
        clear_entry();
        k0 = kv_cnt;
        for (int i = 0; i < 5; i++) begin
            keys = 16'h0002;
            repeat (FRAME) @(negedge clock);
            keys = 16'h0000;
            repeat (FRAME) @(negedge clock);
        end
        repeat (8*FRAME) @(negedge clock);
        check_val("bounce_kv", 32'(kv_cnt - k0), 32'd0);

        // Two keys together decode as none
        k0 = kv_cnt;
        keys = 16'h0006;
        repeat (10*FRAME) @(negedge clock);
        keys = 16'h0000;
        repeat (8*FRAME) @(negedge clock);
        check_val("multi_kv", 32'(kv_cnt - k0), 32'd0);
        check_val("multi_value", value, 32'd0);

        // clear in the accept cycle wins but key_valid still pulses
        press_key(8);
        check_val("pre_clr_value", value, 32'd8);
        align_frame();
        keys = 16'h0080;
        repeat (127) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check_val("clracc_kv", 32'(key_valid), 32'd1);
        check_val("clracc_code", 32'(key_code), 32'd7);
        check_val("clracc_value", value, 32'd0);
        check_val("clracc_count", 32'(digit_count), 32'd0);
        keys = 16'h0000;
        repeat (8*FRAME) @(negedge clock);

`ifdef KEYPAD_SIGN_KEY_EN
        clear_entry();
        press_key(4); press_key(2); press_key(15);
        check_val("sign_neg42", value, 32'hFFFFFFD6);
        press_key(14);
        check_val("bs_neg4", value, 32'hFFFFFFFC);
        check_val("bs_cnt1", 32'(digit_count), 32'd1);
        press_key(14);
        check_val("bs_zero", value, 32'd0);
        check_val("bs_cnt0", 32'(digit_count), 32'd0);
        press_key(3);
        check_val("sign_cleared", value, 32'd3);
`else
        clear_entry();
        press_key(4); press_key(15); press_key(14);
        check_val("nosign_value", value, 32'd4);
        check_val("nosign_count", 32'(digit_count), 32'd1);
        check_val("nosign_code", 32'(key_code), 32'd14);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
